// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch unit: issues in-order pipelined reads at the PC the
// fetch stage asks for, buffers returned parcels in a small FIFO and presents
// the head with its PC and fault flags. A redirect empties the FIFO and
// drops responses that are still in flight.
module riscv_if_prefetch #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 4,
    parameter int MAX_OUT     = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [XLEN-1:0]           if_nxt_pc,
    input  logic                      if_stall,
    input  logic                      if_flush,
    output logic                      if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]    if_parcel,
    output logic [XLEN-1:0]           if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                      if_parcel_misaligned,
    output logic                      if_parcel_page_fault,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_adr,
    input  logic                      imem_gnt,
    input  logic                      imem_ack,
    input  logic [PARCEL_SIZE-1:0]    imem_rdata,
    input  logic                      imem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = AW + CW + 2;
    localparam int NV = PARCEL_SIZE / 16;
    localparam logic [PARCEL_SIZE-1:0] INSTR_NOP = PARCEL_SIZE'(32'h0000_0013);

    // Parcel FIFO storage and the PC tags of requests still on the bus.
    logic [PARCEL_SIZE-1:0] fifo_data [DEPTH];
    logic [XLEN-1:0]        fifo_pc   [DEPTH];
    logic                   fifo_mis  [DEPTH];
    logic                   fifo_pf   [DEPTH];
    logic [XLEN-1:0]        tag_pc    [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [AW:0]   fifo_cnt;
    logic [CW-1:0] outstanding, discard;

    logic          head_valid, aligned, may_issue, issue, push_mis;
    logic          ack_ok, push_ack, push, pop;
    logic [SW-1:0] credit_used;

    // Every parcel that will land in the FIFO (queued, or in flight and not
    // to be discarded) holds a slot, so a push can never find the FIFO full.
    assign credit_used = SW'(fifo_cnt) + SW'(outstanding) - SW'(discard);
    assign aligned     = (if_nxt_pc[1:0] == 2'b00);
    assign may_issue   = rstn && !if_flush && (outstanding < CW'(MAX_OUT))
                         && (credit_used < SW'(DEPTH));

    assign imem_req = aligned && may_issue;
    assign imem_adr = if_nxt_pc;
    assign issue    = imem_req && imem_gnt;
    // A misaligned PC bypasses the bus, so it waits for the bus to drain to
    // keep parcels in program order.
    assign push_mis = !aligned && may_issue && (outstanding == '0);
    assign if_stall_nxt_pc = !(issue || push_mis);

    assign ack_ok     = imem_ack && (outstanding != '0);
    assign push_ack   = ack_ok && (discard == '0) && !if_flush;
    assign push       = push_ack || push_mis;
    assign head_valid = (fifo_cnt != '0);
    assign pop        = head_valid && !if_stall && !if_flush;

    assign if_parcel            = head_valid ? fifo_data[rd_ptr] : INSTR_NOP;
    assign if_parcel_pc         = head_valid ? fifo_pc[rd_ptr]   : '0;
    assign if_parcel_misaligned = head_valid && fifo_mis[rd_ptr];
    assign if_parcel_page_fault = head_valid && fifo_pf[rd_ptr];
    assign if_parcel_valid      = {NV{head_valid}};

    // Control state: pointers, occupancy, outstanding and discard counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every counter update sees
            // the pre-edge values of its neighbours, whatever the statement order.
            if (issue)  tag_wr <= tag_wr + 1'b1;
            if (ack_ok) tag_rd <= tag_rd + 1'b1;
            outstanding <= outstanding + CW'(issue) - CW'(ack_ok);
            if (if_flush) begin
                // Responses still owed after this cycle must all be dropped.
                discard  <= outstanding - CW'(ack_ok);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (ack_ok && (discard != '0)) discard <= discard - 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    // Data storage: write the pushed parcel and the tag of a granted request.
    // NOTE: storage arrays are not reset; occupancy and pointers alone decide
    // which entries are meaningful, and the output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_mis ? INSTR_NOP : imem_rdata;
            fifo_pc[wr_ptr]   <= push_mis ? if_nxt_pc : tag_pc[tag_rd];
            fifo_mis[wr_ptr]  <= push_mis;
            fifo_pf[wr_ptr]   <= !push_mis && imem_err;
        end
        if (issue) tag_pc[tag_wr] <= if_nxt_pc;
    end

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Self-checking bench for riscv_if_prefetch: a directed vector table, a few
// hand-written multi-cycle corner sequences, and a randomized run against a
// queue-based reference model of the prefetcher.
module tb_riscv_if_prefetch;

    localparam int XLEN = 32, PS = 32, DEPTH = 4, MAX_OUT = 2, NV = PS / 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk, rstn;
    logic [31:0]   if_nxt_pc;
    logic          if_stall, if_flush, if_stall_nxt_pc;
    logic [31:0]   if_parcel, if_parcel_pc;
    logic [NV-1:0] if_parcel_valid;
    logic          if_parcel_misaligned, if_parcel_page_fault;
    logic          imem_req, imem_gnt, imem_ack, imem_err;
    logic [31:0]   imem_adr, imem_rdata;

    riscv_if_prefetch #(.XLEN(XLEN), .PARCEL_SIZE(PS), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn),
        .if_nxt_pc(if_nxt_pc), .if_stall(if_stall), .if_flush(if_flush),
        .if_stall_nxt_pc(if_stall_nxt_pc),
        .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc), .if_parcel_valid(if_parcel_valid),
        .if_parcel_misaligned(if_parcel_misaligned), .if_parcel_page_fault(if_parcel_page_fault),
        .imem_req(imem_req), .imem_adr(imem_adr), .imem_gnt(imem_gnt),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Apply inputs just after the rising edge, then move to the falling edge to sample.
    task automatic drive(input logic [31:0] pc, input logic stall, input logic flush,
                         input logic gnt, input logic ack, input logic err, input logic [31:0] rdata);
        if_nxt_pc  = pc;
        if_stall   = stall;
        if_flush   = flush;
        imem_gnt   = gnt;
        imem_ack   = ack;
        imem_err   = err;
        imem_rdata = rdata;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic check_outputs);
        rstn = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        if (check_outputs) begin
            check("rst_req", imem_req, 0);
            check("rst_stall_nxt_pc", if_stall_nxt_pc, 1);
            check("rst_valid", if_parcel_valid, 0);
            check("rst_parcel", if_parcel, NOP);
            check("rst_pc", if_parcel_pc, 0);
            check("rst_misaligned", if_parcel_misaligned, 0);
            check("rst_page_fault", if_parcel_page_fault, 0);
        end
        tick();
        rstn = 1'b1;
    endtask

    task automatic check_head(input string name, input logic [31:0] pc, input logic [31:0] data,
                              input logic mis, input logic pf);
        check({name, "_valid"}, if_parcel_valid, {NV{1'b1}});
        check({name, "_pc"}, if_parcel_pc, pc);
        check({name, "_data"}, if_parcel, data);
        check({name, "_mis"}, if_parcel_misaligned, mis);
        check({name, "_pf"}, if_parcel_page_fault, pf);
    endtask

    // Directed vectors: streaming, misaligned PC, bus error, flush.
    typedef struct {
        logic [31:0] pc;
        logic        stall, flush, gnt, ack, err;
        logic [31:0] rdata;
        logic        e_req, e_snp, e_valid;
        logic [31:0] e_pc, e_parcel;
        logic        e_mis, e_pf;
    } vec_t;

    vec_t tbl [12];

    // Reference model state for the randomized run.
    typedef struct {
        logic [31:0] data, pc;
        logic        mis, pf;
    } entry_t;

    typedef struct {
        logic [31:0] pc, data;
        logic        err;
        int          ready;
        logic        dropped;
    } infl_t;

    entry_t      fq [$];
    infl_t       iq [$];
    infl_t       e;
    logic [31:0] nxt_pc;
    logic        m_flush, m_stall, m_gnt, m_ack, m_aligned, m_may, m_req, m_issue, m_pmis;
    int          live;

    initial begin
        rstn = 1'b0;
        tbl[0]  = '{32'h200, 0, 0, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0,   32'h0,         0, 0};
        tbl[1]  = '{32'h204, 0, 0, 1, 1, 0, 32'hC0DE0200,  1, 0, 0, 32'h0,   32'h0,         0, 0};
        tbl[2]  = '{32'h208, 0, 0, 1, 1, 0, 32'hC0DE0204,  1, 0, 1, 32'h200, 32'hC0DE0200,  0, 0};
        tbl[3]  = '{32'h20C, 0, 0, 0, 1, 0, 32'hC0DE0208,  1, 1, 1, 32'h204, 32'hC0DE0204,  0, 0};
        tbl[4]  = '{32'h20C, 0, 0, 0, 0, 0, 32'h0,         1, 1, 1, 32'h208, 32'hC0DE0208,  0, 0};
        tbl[5]  = '{32'h202, 0, 0, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,         0, 0};
        tbl[6]  = '{32'h300, 1, 0, 1, 0, 0, 32'h0,         1, 0, 1, 32'h202, NOP,           1, 0};
        tbl[7]  = '{32'h304, 0, 0, 0, 1, 1, 32'hC0DE0300,  1, 1, 1, 32'h202, NOP,           1, 0};
        tbl[8]  = '{32'h304, 1, 0, 1, 0, 0, 32'h0,         1, 0, 1, 32'h300, 32'hC0DE0300,  0, 1};
        tbl[9]  = '{32'h308, 0, 0, 0, 1, 0, 32'hC0DE0304,  1, 1, 1, 32'h300, 32'hC0DE0300,  0, 1};
        tbl[10] = '{32'h308, 0, 0, 0, 0, 0, 32'h0,         1, 1, 1, 32'h304, 32'hC0DE0304,  0, 0};
        tbl[11] = '{32'h400, 0, 1, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0,   32'h0,         0, 0};

        do_reset(1'b1);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].pc, tbl[i].stall, tbl[i].flush, tbl[i].gnt, tbl[i].ack, tbl[i].err, tbl[i].rdata);
            check($sformatf("vec%0d_req", i), imem_req, tbl[i].e_req);
            if (tbl[i].e_req) check($sformatf("vec%0d_adr", i), imem_adr, tbl[i].pc);
            check($sformatf("vec%0d_stall_nxt_pc", i), if_stall_nxt_pc, tbl[i].e_snp);
            if (tbl[i].e_valid)
                check_head($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_parcel, tbl[i].e_mis, tbl[i].e_pf);
            else
                check($sformatf("vec%0d_valid", i), if_parcel_valid, 0);
            tick();
        end

        // Backpressure: FIFO fills to DEPTH, requests stop, nothing lost on release.
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(32'h1000 + 32'(4 * (c < 4 ? c : 4)), 1'b1, 1'b0, 1'b1, (c >= 1 && c <= 4), 1'b0,
                  32'hC0DE0000 | (32'h1000 + 32'(4 * (c - 1))));
            check($sformatf("bp%0d_req", c), imem_req, (c < 4));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(32'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check_head($sformatf("bp_drain%0d", k), 32'h1000 + 32'(4 * k),
                       32'hC0DE1000 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        drive(32'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("bp_drained_valid", if_parcel_valid, 0);
        tick();

        // Flush with two reads outstanding: their 0xDEAD responses never show.
        do_reset(1'b0);
        drive(32'h500, 0, 0, 1, 0, 0, 32'h0);          tick();
        drive(32'h504, 0, 0, 1, 0, 0, 32'h0);          tick();
        drive(32'h600, 0, 1, 1, 0, 0, 32'h0);
        check("fl_flush_req", imem_req, 0);            tick();
        drive(32'h600, 0, 0, 1, 1, 0, 32'hDEAD);
        check("fl_full_req", imem_req, 0);
        check("fl_c3_valid", if_parcel_valid, 0);      tick();
        drive(32'h600, 0, 0, 1, 1, 0, 32'hDEAD);
        check("fl_c4_req", imem_req, 1);
        check("fl_c4_valid", if_parcel_valid, 0);      tick();
        drive(32'h604, 0, 0, 0, 1, 0, 32'hC0DE0600);
        check("fl_c5_valid", if_parcel_valid, 0);      tick();
        drive(32'h604, 0, 0, 0, 0, 0, 32'h0);
        check_head("fl_redirect", 32'h600, 32'hC0DE0600, 1'b0, 1'b0); tick();

        // Flush coinciding with ack and pop: discard must equal outstanding-1.
        do_reset(1'b0);
        drive(32'h700, 0, 0, 1, 0, 0, 32'h0);          tick();
        drive(32'h704, 0, 0, 1, 1, 0, 32'hC0DE0700);   tick();
        drive(32'h708, 1, 0, 1, 0, 0, 32'h0);
        check_head("fap_pre", 32'h700, 32'hC0DE0700, 1'b0, 1'b0); tick();
        drive(32'h800, 0, 1, 1, 1, 0, 32'hC0DE0704);
        check("fap_flush_req", imem_req, 0);           tick();
        drive(32'h800, 0, 0, 1, 0, 0, 32'h0);
        check("fap_empty_after_flush", if_parcel_valid, 0);
        check("fap_c4_req", imem_req, 1);              tick();
        drive(32'h804, 0, 0, 1, 1, 0, 32'hC0DE0708);
        check("fap_c5_req", imem_req, 0);
        check("fap_c5_valid", if_parcel_valid, 0);     tick();
        drive(32'h804, 0, 0, 0, 1, 0, 32'hC0DE0800);
        check("fap_c6_valid", if_parcel_valid, 0);     tick();
        drive(32'h804, 0, 0, 0, 0, 0, 32'h0);
        check_head("fap_redirect", 32'h800, 32'hC0DE0800, 1'b0, 1'b0); tick();

        // Randomized run against the queue model.
        do_reset(1'b0);
        fq.delete();
        iq.delete();
        nxt_pc = 32'h2000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            m_flush = ($urandom_range(0, 19) == 0);
            m_stall = ($urandom_range(0, 2) == 0);
            m_gnt   = ($urandom_range(0, 3) != 0);
            m_ack   = (iq.size() > 0) && (iq[0].ready <= cyc) && ($urandom_range(0, 3) != 0);
            drive(nxt_pc, m_stall, m_flush, m_gnt, m_ack, m_ack ? iq[0].err : 1'b0,
                  m_ack ? iq[0].data : $urandom);

            live = 0;
            foreach (iq[i]) if (!iq[i].dropped) live++;
            m_may     = !m_flush && (iq.size() < MAX_OUT) && (fq.size() + live < DEPTH);
            m_aligned = (nxt_pc[1:0] == 2'b00);
            m_req     = m_aligned && m_may;
            m_issue   = m_req && m_gnt;
            m_pmis    = !m_aligned && m_may && (iq.size() == 0);

            check("rnd_req", imem_req, m_req);
            if (m_req) check("rnd_adr", imem_adr, nxt_pc);
            check("rnd_stall_nxt_pc", if_stall_nxt_pc, !(m_issue || m_pmis));
            if (fq.size() > 0) check_head("rnd_head", fq[0].pc, fq[0].data, fq[0].mis, fq[0].pf);
            else check("rnd_valid", if_parcel_valid, 0);

            if (m_ack) begin
                assert (iq.size() > 0) else $error("ack with no outstanding request");
                e = iq.pop_front();
            end
            if (m_flush) begin
                fq.delete();
                foreach (iq[i]) iq[i].dropped = 1'b1;
            end else begin
                if (fq.size() > 0 && !m_stall) void'(fq.pop_front());
                if (m_ack && !e.dropped) fq.push_back('{e.data, e.pc, 1'b0, e.err});
                if (m_pmis) fq.push_back('{NOP, nxt_pc, 1'b1, 1'b0});
            end
            if (m_issue)
                iq.push_back('{nxt_pc, nxt_pc ^ 32'h5A5A_0000, ($urandom_range(0, 9) == 0),
                               cyc + $urandom_range(1, 3), 1'b0});

            if (m_flush) nxt_pc = {16'h0, 8'($urandom_range(0, 255)), 8'h00};
            else if (m_issue || m_pmis) begin
                nxt_pc = {nxt_pc[31:2], 2'b00} + 32'd4;
                if ($urandom_range(0, 9) == 0) nxt_pc[1:0] = 2'($urandom_range(1, 3));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
